sram_arbiter: RTL and testbench

- Sequences all accesses to the shared external 8-bit SRAM on behalf of three requesters:
  - port 2: AVR host
  - port 1: CoCo SCS register window
  - port 0: CoCo CTS ROM window
- Owns all SRAM control/address/data-drive timing and returns read data plus a one-cycle acknowledge per request.
- Replaces the inline pending-request flags and tick counter in the FDC glue with a reusable, separately verifiable block.

---
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Arbiter for the shared external 8-bit SRAM: serialises AVR (2), SCS (1) and CTS (0) accesses.
// Define SRAM_ARB_ROUND_ROBIN_EN for rotating priority; default build is fixed priority 2 > 1 > 0.
module sram_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ACCESS_TICKS = 4
) (
    input  logic                  clock_50,
    input  logic                  reset_n,
    input  logic [2:0]            req,
    input  logic [2:0]            req_rw,
    input  logic [3*ADDR_W-1:0]   req_addr,
    input  logic [3*DATA_W-1:0]   req_wdata,
    output logic [2:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic [1:0]            grant_id,
    output logic [ADDR_W-1:0]     sram_addrbus,
    output logic [DATA_W-1:0]     sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_W-1:0]     sram_dq_in,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
);

    localparam int unsigned CNT_W      = (ACCESS_TICKS > 1) ? $clog2(ACCESS_TICKS) : 1;
    localparam logic [1:0]  GRANT_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rw_q;
    logic [2:0]          ack_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                busy_q;
    logic [1:0]          grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   dq_out_q;
    logic                dq_oe_q;
    logic                we_n_q;
    logic                oe_n_q;

    logic [1:0]          win_c;
    logic                sel_rw_c;
    logic [ADDR_W-1:0]   sel_addr_c;
    logic [DATA_W-1:0]   sel_wdata_c;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [1:0]          last_q;

    // Search order starts just below the last winner, wrapping 0 -> 2 -> 1 -> 0.
    always_comb begin
        win_c = 2'd0;
        case (last_q)
            2'd2:    win_c = req[1] ? 2'd1 : (req[0] ? 2'd0 : 2'd2);
            2'd1:    win_c = req[0] ? 2'd0 : (req[2] ? 2'd2 : 2'd1);
            default: win_c = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
        endcase
    end
`else
    // Fixed priority: AVR over SCS over CTS.
    always_comb begin
        win_c = 2'd0;
        if (req[2]) begin
            win_c = 2'd2;
        end else if (req[1]) begin
            win_c = 2'd1;
        end
    end
`endif

    // Route the winning port's transfer fields.
    always_comb begin
        sel_rw_c    = req_rw[0];
        sel_addr_c  = req_addr[0 +: ADDR_W];
        sel_wdata_c = req_wdata[0 +: DATA_W];
        case (win_c)
            2'd2: begin
                sel_rw_c    = req_rw[2];
                sel_addr_c  = req_addr[2*ADDR_W +: ADDR_W];
                sel_wdata_c = req_wdata[2*DATA_W +: DATA_W];
            end
            2'd1: begin
                sel_rw_c    = req_rw[1];
                sel_addr_c  = req_addr[ADDR_W +: ADDR_W];
                sel_wdata_c = req_wdata[DATA_W +: DATA_W];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            ack_q    <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            grant_q  <= GRANT_NONE;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q   <= 2'd0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        state_q <= ST_ACCESS;
                        busy_q  <= 1'b1;
                        grant_q <= win_c;
                        addr_q  <= sel_addr_c;
                        rw_q    <= sel_rw_c;
                        cnt_q   <= CNT_W'(ACCESS_TICKS - 1);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                        last_q  <= win_c;
`endif
                        if (sel_rw_c) begin
                            oe_n_q  <= 1'b0;
                            we_n_q  <= 1'b1;
                            dq_oe_q <= 1'b0;
                        end else begin
                            we_n_q   <= 1'b0;
                            oe_n_q   <= 1'b1;
                            dq_oe_q  <= 1'b1;
                            dq_out_q <= sel_wdata_c;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == '0) begin
                        if (rw_q) begin
                            rdata_q <= sram_dq_in;
                        end
                        we_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        ack_q   <= 3'b001 << grant_q;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // Write data is held one cycle past the we_n rise.
                    dq_oe_q <= 1'b0;
                    busy_q  <= 1'b0;
                    grant_q <= GRANT_NONE;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack          = ack_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign grant_id     = grant_q;
    assign sram_addrbus = addr_q;
    assign sram_dq_out  = dq_out_q;
    assign sram_dq_oe   = dq_oe_q;
    assign sram_we_n    = we_n_q;
    assign sram_oe_n    = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed table, multi-cycle corner sequences, then random traffic vs a transaction model.
module tb_sram_arbiter;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  req_rw;
    logic [47:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  ack;
    logic [7:0]  rdata;
    logic        busy;
    logic [1:0]  grant_id;
    logic [15:0] sram_addrbus;
    logic [7:0]  sram_dq_out;
    logic        sram_dq_oe;
    logic [7:0]  sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_arbiter #(.ADDR_W(16), .DATA_W(8), .ACCESS_TICKS(T)) dut (
        .clock_50     (clk),
        .reset_n      (rst_n),
        .req          (req),
        .req_rw       (req_rw),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .ack          (ack),
        .rdata        (rdata),
        .busy         (busy),
        .grant_id     (grant_id),
        .sram_addrbus (sram_addrbus),
        .sram_dq_out  (sram_dq_out),
        .sram_dq_oe   (sram_dq_oe),
        .sram_dq_in   (sram_dq_in),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Behavioural async SRAM: drives data only while oe_n is low, stores only while driven.
    bit [7:0]    mem [65536];
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (!sram_we_n && sram_dq_oe) mem[sram_addrbus] <= sram_dq_out;
    end
    assign sram_dq_in = !sram_oe_n ? mem[sram_addrbus] : 8'h00;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic set_port(input int p, input bit rw, input logic [15:0] a, input logic [7:0] wd);
        req_rw[p]          = rw;
        req_addr[p*16 +: 16] = a;
        req_wdata[p*8 +: 8]  = wd;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_grant"}, grant_id, 3);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_dq_oe"}, sram_dq_oe, 0);
        chk({tag, "_we_n"}, sram_we_n, 1);
        chk({tag, "_oe_n"}, sram_oe_n, 1);
    endtask

    // One isolated transaction from an idle arbiter; checks latency, strobes and data.
    task automatic do_txn(input int p, input bit rw, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd);
        int ack_at = -1;
        int oe_cnt = 0;
        int we_cnt = 0;
        int doe_cnt = 0;
        logic [2:0] ack_v = 3'b000;
        set_port(p, rw, a, wd);
        req[p] = 1'b1;
        for (int n = 1; n <= 20 && ack_at < 0; n++) begin
            tick();
            if (!sram_oe_n) oe_cnt++;
            if (!sram_we_n) we_cnt++;
            if (sram_dq_oe) doe_cnt++;
            if (n == 1) begin
                chk("txn_grant", grant_id, p);
                chk("txn_addr", sram_addrbus, a);
                if (!rw) chk("txn_dq_out", sram_dq_out, wd);
            end
            if (ack != 3'b000) begin
                ack_at = n;
                ack_v  = ack;
                req[p] = 1'b0;
                chk("txn_done_addr", sram_addrbus, a);
            end
        end
        chk("txn_latency", ack_at, T + 1);
        chk("txn_ack_port", ack_v, 32'(1) << p);
        chk("txn_oe_cycles", oe_cnt, rw ? T : 0);
        chk("txn_we_cycles", we_cnt, rw ? 0 : T);
        chk("txn_dq_oe_cycles", doe_cnt, rw ? 0 : T + 1);
        chk("txn_rdata", rdata, exp_rd);
        tick();
        check_idle("txn_after");
    endtask

    int ack_cyc_a [8];
    int ack_port_a[8];
    logic [7:0] ack_rd_a[8];

    // Runs from cycle 0 (reqs already set) until nack acks; reqs dropped on ack if requested.
    task automatic run_acks(input int nack, input bit drop_on_ack);
        int got = 0;
        for (int n = 1; n <= 80 && got < nack; n++) begin
            tick();
            chk("seq_we_oe_excl", (!sram_we_n && !sram_oe_n), 0);
            if (ack != 3'b000) begin
                ack_cyc_a[got]  = n;
                ack_port_a[got] = ack[2] ? 2 : (ack[1] ? 1 : 0);
                ack_rd_a[got]   = rdata;
                got++;
                if (drop_on_ack) req = req & ~ack;
            end
        end
        req = 3'b000;
        if (got < nack) chk("seq_ack_timeout", got, nack);
    endtask

    typedef struct {
        int         port;
        bit         rw;
        logic [15:0] addr;
        logic [7:0] wdata;
        bit         pre;
        logic [7:0] pre_val;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    // Transaction-level reference model for the random phase.
    int last_g;

    function automatic int pick(input logic [2:0] r);
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 3; i++) begin
            int p = (last_g + 3 - i) % 3;
            if (r[p]) return p;
        end
        return 0;
`else
        for (int p = 2; p >= 0; p--) begin
            if (r[p]) return p;
        end
        return 0;
`endif
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int free_cyc, grant_cyc, exp_ack_cyc, exp_port, exp_k, w, k;
        bit exp_rw, e_busy;
        logic [7:0] exp_wd, last_rd;
        logic [7:0] ref_k [16];
        int r_k [3];
        int gap [3];
        int rr_exp [4];

        rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        tick();
        tick();
        check_idle("rst");
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", sram_addrbus, 0);
        chk("rst_dq_out", sram_dq_out, 0);
        rst_n = 1'b1;
        tick();

        // Directed single transactions; writes check rdata is held from the previous read.
        tbl[0] = '{1, 1'b1, 16'h0017, 8'h00, 1'b1, 8'hA5, 8'hA5};
        tbl[1] = '{2, 1'b0, 16'h2040, 8'h3C, 1'b0, 8'h00, 8'hA5};
        tbl[2] = '{0, 1'b1, 16'h2040, 8'h00, 1'b0, 8'h00, 8'h3C};
        tbl[3] = '{0, 1'b0, 16'hFFFF, 8'h81, 1'b0, 8'h00, 8'h3C};
        tbl[4] = '{1, 1'b1, 16'hFFFF, 8'h00, 1'b0, 8'h00, 8'h81};
        tbl[5] = '{2, 1'b1, 16'h0000, 8'h00, 1'b1, 8'h5A, 8'h5A};
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].pre) poke(tbl[i].addr, tbl[i].pre_val);
            do_txn(tbl[i].port, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
        end

        // Reset in the second ACCESS cycle of a write.
        set_port(2, 1'b0, 16'h1234, 8'h77);
        req = 3'b100;
        tick();
        chk("abort_we_low", sram_we_n, 0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_idle("abort");
        chk("abort_rdata", rdata, 0);
        chk("abort_addr", sram_addrbus, 0);
        chk("abort_dq_out", sram_dq_out, 0);
        req = 3'b000;
        tick();
        chk("abort_no_ack", ack, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_no_ack2", ack, 0);
        do_txn(2, 1'b0, 16'h1234, 8'h77, 8'h00);
        do_txn(1, 1'b1, 16'h1234, 8'h00, 8'h77);

        // Three-way contention.
        poke(16'h0001, 8'h11);
        poke(16'h8002, 8'h22);
        poke(16'h2003, 8'h33);
        reset_pulse();
        set_port(0, 1'b1, 16'h0001, 8'h00);
        set_port(1, 1'b1, 16'h8002, 8'h00);
        set_port(2, 1'b1, 16'h2003, 8'h00);
        req = 3'b111;
        run_acks(3, 1'b1);
        chk("cont_port0", ack_port_a[0], 2);
        chk("cont_port1", ack_port_a[1], 1);
        chk("cont_port2", ack_port_a[2], 0);
        chk("cont_cyc0", ack_cyc_a[0], T + 1);
        chk("cont_gap1", ack_cyc_a[1] - ack_cyc_a[0], T + 2);
        chk("cont_gap2", ack_cyc_a[2] - ack_cyc_a[1], T + 2);
        chk("cont_rd0", ack_rd_a[0], 8'h33);
        chk("cont_rd1", ack_rd_a[1], 8'h22);
        chk("cont_rd2", ack_rd_a[2], 8'h11);
        tick();
        check_idle("cont_after");

        // Port 0 holds req across three back-to-back accesses.
        set_port(0, 1'b1, 16'h0001, 8'h00);
        req = 3'b001;
        run_acks(3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("b2b_port", ack_port_a[i], 0);
            chk("b2b_cyc", ack_cyc_a[i], (i + 1) * (T + 2) - 1);
        end
        begin
            int extra = 0;
            for (int n = 0; n < 2 * (T + 2); n++) begin
                tick();
                if (ack != 3'b000) extra++;
            end
            chk("b2b_no_double", extra, 0);
        end

        // Ports 2 and 0 requesting continuously.
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_exp = '{2, 0, 2, 0};
`else
        rr_exp = '{2, 2, 2, 2};
`endif
        reset_pulse();
        set_port(2, 1'b1, 16'h2003, 8'h00);
        set_port(0, 1'b1, 16'h0001, 8'h00);
        req = 3'b101;
        run_acks(4, 1'b0);
        for (int i = 0; i < 4; i++) chk("rr_port", ack_port_a[i], rr_exp[i]);
        tick();

        // Random traffic against the transaction model.
        reset_pulse();
        free_cyc = cyc; grant_cyc = -100; exp_ack_cyc = -100; exp_port = 0; exp_k = 0;
        exp_rw = 1'b0; exp_wd = '0; last_rd = 8'h00; last_g = 0;
        for (int i = 0; i < 16; i++) ref_k[i] = 8'h00;
        for (int p = 0; p < 3; p++) begin r_k[p] = 0; gap[p] = 0; end
        for (int s = 0; s < 1500; s++) begin
            tick();
            k = cyc;
            e_busy = (k > grant_cyc) && (k <= exp_ack_cyc);
            chk("rnd_ack", ack, (k == exp_ack_cyc) ? (32'(1) << exp_port) : 0);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_grant", grant_id, e_busy ? exp_port : 3);
            if (k == exp_ack_cyc) begin
                if (exp_rw) last_rd = ref_k[exp_k];
                else ref_k[exp_k] = exp_wd;
            end
            chk("rnd_rdata", rdata, last_rd);
            chk("rnd_we_oe_excl", (!sram_we_n && !sram_oe_n), 0);
            chk("rnd_dq_oe_vs_oe", (sram_dq_oe && !sram_oe_n), 0);
            for (int p = 0; p < 3; p++) begin
                if (req[p] && ack[p]) begin
                    req[p] = 1'b0;
                    gap[p] = $urandom_range(0, 3);
                end else if (!req[p]) begin
                    if (gap[p] > 0) gap[p]--;
                    else if ($urandom_range(0, 2) == 0) begin
                        r_k[p] = $urandom_range(0, 15);
                        set_port(p, 1'($urandom_range(0, 1)), 16'(16'h4000 + r_k[p] * 16'h0101),
                                 8'($urandom));
                        req[p] = 1'b1;
                    end
                end
            end
            if (k >= free_cyc && req != 3'b000) begin
                w = pick(req);
                grant_cyc   = k;
                exp_ack_cyc = k + T + 1;
                free_cyc    = k + T + 2;
                exp_port    = w;
                exp_rw      = req_rw[w];
                exp_k       = r_k[w];
                exp_wd      = req_wdata[w*8 +: 8];
                last_g      = w;
            end
        end
        req = 3'b000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
